key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Sits directly downstream of the PS/2 scan-code decoder.
- Consumes its 6-bit level vector of held actions: W, A, S, D, Space, Enter.
- Converts level changes into discrete press/release events, adds auto-repeat for held keys, and buffers events in a first-word-fall-through FIFO.
- The processor side pops one event at a time with a valid/ready handshake. No key transition is lost.

Parameters:
- DEPTH, 8: FIFO entries. Power of two, at least 2.
- REPEAT_DELAY, 25000000: cycles from a press event to the first repeat (0.5 s at 50 MHz).
- REPEAT_RATE, 5000000: cycles between subsequent repeats.
- REPEAT_MASK, 6'b001111: keys eligible for auto-repeat. Bit i = key i.

Ports:
- clk  in  1  system clock. Same domain as the decoder.
- reset  in  1  synchronous, active-high reset.
- keys_in  in  6  held-action levels. Bit i = decoder action i: 0 W, 1 A, 2 S, 3 D, 4 Space, 5 Enter.
- evt_ready  in  1  consumer pops the head event when evt_valid is also high.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  8  head event. [7] 1=press, 0=release. [6] 1=auto-repeat. [5:3] zero. [2:0] key id 0..5.
- evt_count  out  clog2(DEPTH)+1  current occupancy.
- drop_flag  out  1  sticky: an auto-repeat was discarded because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high):
  - keys_q, seen, FIFO pointers and count, rep_cnt, rep_active, drop_flag all 0.
  - evt_valid=0, evt_count=0. evt_data don't-care.
  - Reset mid-stream discards all queued events.
  - Keys still held after reset produce fresh press events, since seen=0.
- Input stage:
  - keys_q <= keys_in every cycle.
  - pending = keys_q ^ seen.
- Edge arbitration:
  - The lowest-index set bit of pending wins, one event per cycle.
  - Pushed event: data = {keys_q[i], 0, 3'b0, i}. On push, seen[i] <= keys_q[i].
  - If the push is blocked, seen is unchanged and the event stays pending. Edges are never lost.
  - A press followed by a release of the same key while blocked collapses: pending clears and no event is emitted.
- Push allowed when evt_count < DEPTH, or when a pop occurs in the same cycle.
- FIFO:
  - FWFT: evt_data = mem[rd_ptr] combinationally.
  - evt_valid = (evt_count != 0).
  - Pop when evt_valid && evt_ready.
  - Simultaneous push and pop: count unchanged, including when full.
  - Pointers wrap modulo DEPTH.
  - evt_ready while empty has no effect.
- Latency: a keys_in change at edge k gives keys_q at edge k, FIFO write at edge k+1, and evt_valid high after edge k+1 (FIFO empty, no contention).
- Auto-repeat:
  - Pushing a press event for key i with REPEAT_MASK[i]=1: rep_key <= i, rep_active <= 1, rep_cnt <= 0, phase <= DELAY.
  - Pushing a press of a non-maskable key, or a release of rep_key: rep_active <= 0.
  - While rep_active: rep_cnt increments each cycle.
  - When rep_cnt reaches (phase==DELAY ? REPEAT_DELAY-1 : REPEAT_REPEAT_RATE_MINUS_ONE), rep_cnt <= 0 and phase <= RATE. Here REPEAT_REPEAT_RATE_MINUS_ONE means REPEAT_RATE-1.
  - At that terminal count, push {1, 1, 3'b0, rep_key} if no edge event is pushed that cycle and a push is allowed.
  - If an edge event wins the slot, the repeat is skipped silently.
  - If the FIFO is full, the repeat is discarded and drop_flag <= 1.
  - Repeats are never retried.
  - Counter width is sized for max(REPEAT_DELAY, REPEAT_RATE).
- drop_flag clears only on reset.
- Edge events have priority over repeat events in the same cycle.

Test Plan:
Bench uses DEPTH=4, REPEAT_DELAY=8, REPEAT_RATE=3.
1. Reset, then keys_in=6'b000001 at edge 0 → evt_valid high after edge 1 with evt_data=8'h80. Pop → evt_valid=0. Clear keys_in → 8'h00 (release W).
2. keys_in 0→6'b100110 in one cycle, evt_ready=0 → events 8'h81, 8'h82, 8'h85 on consecutive cycles, in that order. evt_count=3.
3. Hold key D (bit 3), evt_ready=1 → 8'h83, then 8'hC3 8 cycles after the press push, then 8'hC3 every 3 cycles. Release → 8'h03 and repeats stop.
4. Hold Enter (bit 5) → only 8'h85, no repeats over 50 cycles.
5. evt_ready=0: fill FIFO to 4, then toggle keys W and S → no push, evt_count stays 4. Pop once per cycle → remaining events delivered in order with no loss. drop_flag=1 if a repeat terminal count hit during full.
6. Assert reset while evt_count=3 and key A held → evt_valid=0 next cycle. After release of reset, 8'h81 is re-emitted. drop_flag=0.

Source files
------------

// File: rtl/key_event_queue.sv
// Key event queue: turns held-action levels into press/release/auto-repeat
// events and buffers them in a first-word-fall-through FIFO.
module key_event_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter logic [5:0]  REPEAT_MASK  = 6'b001111
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               keys_in,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [7:0]               evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     drop_flag
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);
    localparam logic [CW-1:0]   DELAY_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0]   RATE_TC  = CW'(REPEAT_RATE - 1);

    typedef enum logic {PH_DELAY, PH_RATE} phase_t;

    logic [5:0]    keys_q, seen, pending;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] rep_cnt, rep_cnt_n;
    logic [2:0]    rep_key, rep_key_n;
    logic          rep_active, rep_active_n;
    phase_t        phase, phase_n;
    logic          pop, push_ok, edge_push, rep_tc, rep_push, do_push, drop_n;
    logic [2:0]    edge_idx;
    logic [7:0]    push_data;

    assign pending   = keys_q ^ seen;
    assign evt_valid = (evt_count != '0);
    assign evt_data  = mem[rd_ptr];

    // Scan downward so the lowest pending index is the final assignment.
    always_comb begin
        edge_idx = '0;
        for (int unsigned i = 6; i > 0; i--) begin
            if (pending[i-1]) edge_idx = 3'(i - 1);
        end
    end

    always_comb begin
        pop       = evt_valid && evt_ready;
        push_ok   = (evt_count < FULL) || pop;
        edge_push = (pending != '0) && push_ok;
        rep_tc    = rep_active && (rep_cnt == ((phase == PH_DELAY) ? DELAY_TC : RATE_TC));
        rep_push  = rep_tc && !edge_push && push_ok;
        do_push   = edge_push || rep_push;
        push_data = edge_push ? {keys_q[edge_idx], 1'b0, 3'b000, edge_idx}
                              : {2'b11, 3'b000, rep_key};
        drop_n    = drop_flag || (rep_tc && !push_ok);

        rep_active_n = rep_active;
        rep_key_n    = rep_key;
        rep_cnt_n    = rep_cnt;
        phase_n      = phase;
        if (rep_active) rep_cnt_n = rep_cnt + 1'b1;
        if (rep_tc) begin
            rep_cnt_n = '0;
            phase_n   = PH_RATE;
        end
        // A pushed edge restarts or cancels repeating regardless of the timer.
        if (edge_push) begin
            if (keys_q[edge_idx]) begin
                if (REPEAT_MASK[edge_idx]) begin
                    rep_active_n = 1'b1;
                    rep_key_n    = edge_idx;
                    rep_cnt_n    = '0;
                    phase_n      = PH_DELAY;
                end else begin
                    rep_active_n = 1'b0;
                end
            end else if (edge_idx == rep_key) begin
                rep_active_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q     <= '0;
            seen       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            rep_cnt    <= '0;
            rep_key    <= '0;
            rep_active <= 1'b0;
            phase      <= PH_DELAY;
            drop_flag  <= 1'b0;
        end else begin
            keys_q <= keys_in;
            if (edge_push) seen[edge_idx] <= keys_q[edge_idx];
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop) evt_count <= evt_count + 1'b1;
            else if (pop && !do_push) evt_count <= evt_count - 1'b1;
            rep_cnt    <= rep_cnt_n;
            rep_key    <= rep_key_n;
            rep_active <= rep_active_n;
            phase      <= phase_n;
            drop_flag  <= drop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Randomized and directed bench for key_event_queue against a queue-based
// behavioural model of the event stream.
module tb_key_event_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RD    = 8;
    localparam int unsigned RR    = 3;
    localparam logic [5:0]  MASK  = 6'b001111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] keys_in = '0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic [2:0] evt_count;
    logic       drop_flag;

    key_event_queue #(
        .DEPTH(DEPTH),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys_in(keys_in),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .evt_count(evt_count),
        .drop_flag(drop_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: registered key view, per-key reported state, event queue,
    // and a countdown to the next repeat.
    logic [5:0] m_keys = '0;
    logic [5:0] m_seen = '0;
    logic [7:0] m_q[$];
    logic       m_drop = 1'b0;
    logic       m_ract = 1'b0;
    int         m_rleft = 0;
    int         m_rkey = 0;
    logic [5:0] k = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         popd, ok, ep, fire;
        logic [5:0] pend;
        logic [7:0] ev;
        int         idx;
        if (reset) begin
            m_keys = '0;
            m_seen = '0;
            m_q.delete();
            m_drop = 1'b0;
            m_ract = 1'b0;
            m_rleft = 0;
            return;
        end
        popd = (m_q.size() != 0) && evt_ready;
        ok   = (m_q.size() < DEPTH) || popd;
        pend = m_keys ^ m_seen;
        ep   = 1'b0;
        idx  = -1;
        ev   = '0;
        for (int i = 5; i >= 0; i--) if (pend[i]) idx = i;
        if (idx >= 0 && ok) begin
            ep = 1'b1;
            ev = {m_keys[idx], 1'b0, 3'b000, 3'(idx)};
            m_seen[idx] = m_keys[idx];
        end
        fire = 1'b0;
        if (m_ract) begin
            m_rleft--;
            if (m_rleft == 0) begin
                fire = 1'b1;
                m_rleft = RR;
            end
        end
        if (fire && !ok) m_drop = 1'b1;
        if (popd) void'(m_q.pop_front());
        if (ep) begin
            m_q.push_back(ev);
            if (ev[7]) begin
                if (MASK[idx]) begin
                    m_ract = 1'b1;
                    m_rkey = idx;
                    m_rleft = RD;
                end else begin
                    m_ract = 1'b0;
                end
            end else if (idx == m_rkey) begin
                m_ract = 1'b0;
            end
        end else if (fire && ok) begin
            m_q.push_back({2'b11, 3'b000, 3'(m_rkey)});
        end
        m_keys = keys_in;
    endtask

    task automatic compare();
        check("valid", evt_valid, m_q.size() != 0);
        check("count", evt_count, m_q.size());
        if (m_q.size() != 0) check("data", evt_data, m_q[0]);
        check("drop", drop_flag, m_drop);
    endtask

    task automatic cycle(input logic [5:0] kv, input logic rdy);
        keys_in = kv;
        evt_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) cycle(6'b0, 1'b0);
        reset = 1'b0;
        check("rst_count", evt_count, 0);
        check("rst_valid", evt_valid, 0);

        // Single press / pop / release
        cycle(6'b000001, 1'b0);
        check("t1_latency", evt_valid, 0);
        cycle(6'b000001, 1'b0);
        check("t1_press", evt_data, 8'h80);
        cycle(6'b000001, 1'b1);
        check("t1_pop", evt_valid, 0);
        cycle(6'b000000, 1'b0);
        cycle(6'b000000, 1'b0);
        check("t1_release", evt_data, 8'h00);
        repeat (3) cycle(6'b000000, 1'b1);

        // Simultaneous presses arbitrated lowest index first
        repeat (4) cycle(6'b100110, 1'b0);
        check("t2_count", evt_count, 3);
        check("t2_head", evt_data, 8'h81);
        repeat (5) cycle(6'b100110, 1'b0);
        check("t2_norepeat", evt_count, 3);
        cycle(6'b100110, 1'b1);
        check("t2_second", evt_data, 8'h82);
        cycle(6'b100110, 1'b1);
        check("t2_third", evt_data, 8'h85);
        repeat (6) cycle(6'b000000, 1'b1);

        // Auto-repeat on D, none on Enter
        repeat (30) cycle(6'b001000, 1'b1);
        repeat (10) cycle(6'b000000, 1'b1);
        repeat (50) cycle(6'b100000, 1'b1);
        repeat (5) cycle(6'b000000, 1'b1);

        // Full FIFO: blocked edges, collapsed toggles, dropped repeats
        repeat (25) cycle(6'b001000, 1'b0);
        check("t5_full", evt_count, 4);
        check("t5_drop", drop_flag, 1);
        repeat (3) cycle(6'b001101, 1'b0);
        repeat (2) cycle(6'b001000, 1'b0);
        repeat (4) cycle(6'b000101, 1'b0);
        check("t5_stuck", evt_count, 4);
        repeat (12) cycle(6'b000101, 1'b1);
        repeat (8) cycle(6'b000000, 1'b1);

        // Reset mid-stream with A held
        repeat (4) cycle(6'b000111, 1'b0);
        check("t6_count", evt_count, 3);
        reset = 1'b1;
        cycle(6'b000010, 1'b0);
        check("t6_flush", evt_valid, 0);
        reset = 1'b0;
        repeat (2) cycle(6'b000010, 1'b0);
        check("t6_repress", evt_data, 8'h81);
        check("t6_drop", drop_flag, 0);
        repeat (4) cycle(6'b000000, 1'b1);

        // Random traffic with alternating slow and fast consumers
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) k = k ^ (6'd1 << $urandom_range(0, 5));
            reset = ($urandom_range(0, 499) == 0);
            cycle(k, ((i % 400) < 200) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0));
        end
        reset = 1'b0;
        repeat (10) cycle(6'b000000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
